// File: rtl/cpu_ram_banked.sv
// Two-region Avalon-style RAM model with a deterministic wait-state generator
// (none / fixed / LFSR) and a sticky error flag for protocol and decode faults.
module cpu_ram_banked #(
    parameter              INST_FILE      = "",
    parameter logic [31:0] INST_OFFSET    = 32'hBFC00000,
    parameter int          INST_BYTES     = 4096,
    parameter              DATA_FILE      = "",
    parameter logic [31:0] DATA_OFFSET    = 32'h00000000,
    parameter int          DATA_BYTES     = 4096,
    parameter int          WAIT_MODE      = 0,
    parameter int          WAIT_CYCLES    = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          FATAL_ON_ERROR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        error
);

    localparam int INST_WORDS = INST_BYTES / 4;
    localparam int DATA_WORDS = DATA_BYTES / 4;
    localparam int IW = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
    localparam int DW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [32:0] INST_END = {1'b0, INST_OFFSET} + 33'(INST_BYTES);
    localparam logic [32:0] DATA_END = {1'b0, DATA_OFFSET} + 33'(DATA_BYTES);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic {IDLE, STALL} state_t;

    logic [31:0] inst_mem [INST_WORDS];
    logic [31:0] data_mem [DATA_WORDS];

    generate
        if (({1'b0, INST_OFFSET} < DATA_END) && ({1'b0, DATA_OFFSET} < INST_END)) begin : g_overlap
            $fatal(1, "cpu_ram_banked: instruction and data regions overlap");
        end
    endgenerate

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next, n;
    logic [15:0] lfsr, lfsr_next;
    logic        req, accept, drop, fault, inst_hit, data_hit;
    logic [31:0] inst_rel, data_rel, rd_word;
    logic [IW-1:0] inst_idx;
    logic [DW-1:0] data_idx;

    // Subtracting before comparing keeps the decode correct for regions ending at 2^32.
    assign inst_rel = address - INST_OFFSET;
    assign data_rel = address - DATA_OFFSET;
    assign inst_hit = (address >= INST_OFFSET) && (inst_rel < 32'(INST_BYTES));
    assign data_hit = (address >= DATA_OFFSET) && (data_rel < 32'(DATA_BYTES));
    assign inst_idx = inst_rel[IW+1:2];
    assign data_idx = data_rel[DW+1:2];
    assign rd_word  = inst_hit ? inst_mem[inst_idx] : data_mem[data_idx];

    assign req       = read | write;
    assign fault     = (address[1:0] != 2'b00) || !(inst_hit || data_hit) || (read && write);
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    always_comb begin
        n = 4'd0;
        if (WAIT_MODE == 1)
            n = 4'(WAIT_CYCLES);
        else if (WAIT_MODE == 2)
            n = {2'b00, lfsr[1:0]};
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        waitrequest = 1'b0;
        accept      = 1'b0;
        drop        = 1'b0;
        if (reset) begin
            waitrequest = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (n == 4'd0) begin
                            accept = 1'b1;
                        end else begin
                            waitrequest = 1'b1;
                            state_next  = STALL;
                            cnt_next    = n - 4'd1;
                        end
                    end
                end
                STALL: begin
                    if (!req) begin
                        drop       = 1'b1;
                        state_next = IDLE;
                    end else if (cnt != 4'd0) begin
                        waitrequest = 1'b1;
                        cnt_next    = cnt - 4'd1;
                    end else begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lfsr     <= SEED;
            readdata <= 32'h00000000;
            error    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept)
                lfsr <= lfsr_next;
            if (accept && read)
                readdata <= fault ? 32'h00000000 : rd_word;
            if ((accept && fault) || drop)
                error <= 1'b1;
            if ((FATAL_ON_ERROR != 0) && ((accept && fault) || drop))
                $fatal(1, "cpu_ram_banked: bus fault at address %h", address);
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    if (inst_hit)
                        inst_mem[inst_idx][8*i +: 8] <= writedata[8*i +: 8];
                    else
                        data_mem[data_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_ram_banked.sv
// Directed bench for cpu_ram_banked: four instances cover no-wait, fixed-wait (3 and 5)
// and LFSR-wait configurations, all with faults flagged rather than fatal.
module tb_cpu_ram_banked;

    localparam logic [7:0]  MODE_P = {2'd1, 2'd2, 2'd1, 2'd0};
    localparam logic [15:0] WAIT_P = {4'd5, 4'd2, 4'd3, 4'd2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd [4];
    logic        wr [4];
    logic [3:0]  be [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata_o [4];
    logic        wreq [4];
    logic        err [4];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cpu_ram_banked #(
            .WAIT_MODE(int'(MODE_P[2*g +: 2])),
            .WAIT_CYCLES(int'(WAIT_P[4*g +: 4])),
            .LFSR_SEED(16'hACE1),
            .FATAL_ON_ERROR(0)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .read(rd[g]),
            .write(wr[g]),
            .byteenable(be[g]),
            .address(addr[g]),
            .writedata(wdata[g]),
            .readdata(rdata_o[g]),
            .waitrequest(wreq[g]),
            .error(err[g])
        );
    end

    // Presents one transfer at a falling edge, counts stall cycles, returns data after acceptance.
    task automatic do_xfer(input int d, input logic r, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rdv);
        @(negedge clk);
        rd[d] = r; wr[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        stalls = 0;
        #1;
        while (wreq[d] && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (wreq[d]) begin
            total++; bad++;
            $display("[TB] FAIL xfer_timeout dev=%0d waitrequest=1 required 0", d);
        end
        @(posedge clk);
        #1;
        rdv = rdata_o[d];
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            rd[d] = 0; wr[d] = 0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (wreq[d] !== 1'b1) begin
                bad++; $display("[TB] FAIL reset_waitreq dev=%0d got=%b exp=1", d, wreq[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (wreq[d] !== 1'b0 || err[d] !== 1'b0 || rdata_o[d] !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_state dev=%0d got wr=%b err=%b rd=%h exp 0/0/0",
                         d, wreq[d], err[d], rdata_o[d]);
            end
        end
    endtask

    task automatic test_mode0();
        int s;
        logic [31:0] v;
        do_xfer(0, 0, 1, 4'hF, 32'h10, 32'h12345678, s, v);
        total++;
        if (s !== 0) begin bad++; $display("[TB] FAIL m0_write_stalls got=%0d exp=0", s); end
        do_xfer(0, 1, 0, 4'hF, 32'h10, 32'h0, s, v);
        total++;
        if (s !== 0) begin bad++; $display("[TB] FAIL m0_read_stalls got=%0d exp=0", s); end
        total++;
        if (v !== 32'h12345678) begin bad++; $display("[TB] FAIL m0_readdata got=%h exp=12345678", v); end
    endtask

    task automatic test_mode1();
        int s;
        logic [31:0] v;
        do_xfer(1, 0, 1, 4'hF, 32'hBFC00000, 32'h0BADC0DE, s, v);
        total++;
        if (s !== 3) begin bad++; $display("[TB] FAIL m1_write_stalls got=%0d exp=3", s); end
        do_xfer(1, 1, 0, 4'hF, 32'hBFC00000, 32'h0, s, v);
        total++;
        if (s !== 3) begin bad++; $display("[TB] FAIL m1_read_stalls got=%0d exp=3", s); end
        total++;
        if (v !== 32'h0BADC0DE) begin bad++; $display("[TB] FAIL m1_readdata got=%h exp=0badc0de", v); end
        total++;
        if (err[1] !== 1'b0) begin bad++; $display("[TB] FAIL m1_error got=%b exp=0", err[1]); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [31:0] v;
        do_xfer(1, 0, 1, 4'hF, 32'hBFC00FFC, 32'h5A5A0001, s, v);
        do_xfer(1, 1, 0, 4'hF, 32'hBFC00FFC, 32'h0, s, v);
        total++;
        if (s !== 3 || v !== 32'h5A5A0001) begin
            bad++; $display("[TB] FAIL b2b_read got stalls=%0d data=%h exp 3/5a5a0001", s, v);
        end
    endtask

    task automatic test_byte_lanes();
        int s;
        logic [31:0] v;
        do_xfer(0, 0, 1, 4'hF, 32'h20, 32'hAABBCCDD, s, v);
        do_xfer(0, 0, 1, 4'b0101, 32'h20, 32'h11223344, s, v);
        do_xfer(0, 1, 0, 4'h0, 32'h20, 32'h0, s, v);
        total++;
        if (v !== 32'hAA22CC44) begin bad++; $display("[TB] FAIL byte_lanes got=%h exp=aa22cc44", v); end
    endtask

    task automatic test_faults();
        int s;
        logic [31:0] v;
        do_xfer(0, 0, 1, 4'hF, 32'h30, 32'hCAFEF00D, s, v);
        do_xfer(0, 0, 1, 4'h0, 32'h30, 32'h12121212, s, v);
        do_xfer(0, 1, 0, 4'hF, 32'h30, 32'h0, s, v);
        total++;
        if (v !== 32'hCAFEF00D || err[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL be_zero got data=%h err=%b exp cafef00d/0", v, err[0]);
        end
        do_xfer(0, 1, 0, 4'hF, 32'h00000002, 32'h0, s, v);
        total++;
        if (v !== 32'h0 || err[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL misaligned_read got data=%h err=%b exp 00000000/1", v, err[0]);
        end
        do_xfer(0, 0, 1, 4'hF, 32'h80000000, 32'hDEADBEEF, s, v);
        do_xfer(0, 0, 1, 4'hF, 32'h00000032, 32'hFFFFFFFF, s, v);
        do_xfer(0, 1, 1, 4'hF, 32'h00000030, 32'h77777777, s, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL rw_both_read got=%h exp=00000000", v); end
        do_xfer(0, 1, 0, 4'hF, 32'h30, 32'h0, s, v);
        total++;
        if (v !== 32'hCAFEF00D || err[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL fault_discard got data=%h err=%b exp cafef00d/1", v, err[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (err[0] !== 1'b0) begin bad++; $display("[TB] FAIL error_clear got=%b exp=0", err[0]); end
    endtask

    task automatic test_mode2();
        logic [31:0] sb [16];
        logic        sbv [16];
        logic [15:0] ml;
        logic [31:0] v, d, m;
        logic [3:0]  b;
        int          s, idx, exp_s;
        logic        is_read;
        ml = 16'hACE1;
        for (int i = 0; i < 16; i++) begin sbv[i] = 1'b0; sb[i] = 32'h0; end
        for (int i = 0; i < 64; i++) begin
            idx = $urandom_range(0, 15);
            is_read = sbv[idx] && ($urandom_range(0, 1) == 1);
            d = $urandom;
            b = sbv[idx] ? 4'($urandom_range(0, 15)) : 4'hF;
            exp_s = int'(ml[1:0]);
            do_xfer(2, is_read, !is_read, b, 32'h100 + 32'(idx * 4), d, s, v);
            total++;
            if (s !== exp_s) begin
                bad++; $display("[TB] FAIL m2_stalls iter=%0d got=%0d exp=%0d", i, s, exp_s);
            end
            if (is_read) begin
                total++;
                if (v !== sb[idx]) begin
                    bad++; $display("[TB] FAIL m2_data iter=%0d got=%h exp=%h", i, v, sb[idx]);
                end
            end else begin
                m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                sb[idx] = (sb[idx] & ~m) | (d & m);
                sbv[idx] = 1'b1;
            end
            ml = {ml[0] ^ ml[2] ^ ml[3] ^ ml[5], ml[15:1]};
        end
        total++;
        if (err[2] !== 1'b0) begin bad++; $display("[TB] FAIL m2_error got=%b exp=0", err[2]); end
    endtask

    task automatic test_reset_in_stall();
        int s;
        logic [31:0] v;
        do_xfer(3, 0, 1, 4'hF, 32'h40, 32'h01010101, s, v);
        total++;
        if (s !== 5) begin bad++; $display("[TB] FAIL rst_stall_setup got=%0d exp=5", s); end
        @(negedge clk);
        wr[3] = 1'b1; be[3] = 4'hF; addr[3] = 32'h40; wdata[3] = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr[3] = 1'b0;
        #1;
        total++;
        if (wreq[3] !== 1'b1) begin bad++; $display("[TB] FAIL rst_stall_waitreq got=%b exp=1", wreq[3]); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (wreq[3] !== 1'b0 || err[3] !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_stall_idle got wr=%b err=%b exp 0/0", wreq[3], err[3]);
        end
        do_xfer(3, 1, 0, 4'hF, 32'h40, 32'h0, s, v);
        total++;
        if (v !== 32'h01010101) begin bad++; $display("[TB] FAIL rst_stall_mem got=%h exp=01010101", v); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_mode0();
        test_mode1();
        test_back_to_back();
        test_byte_lanes();
        test_faults();
        test_mode2();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
